// File: rtl/serializer_word_feeder_pkg.sv
// Shared types and sizing helpers for the serializer word feeder and its slot counter.
package serializer_feeder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_t;

  localparam logic [7:0] DEFAULT_IDLEWORD = 8'h3C;

  function automatic int nwords(input int frame_w, input int word_w);
    return frame_w / word_w;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_word_feeder_slot_counter.sv
// Enable-gated modulo-MODULUS bit counter; slot marks the enabled edge that closes a word period.
module slot_counter
  import serializer_feeder_pkg::*;
#(
  parameter int MODULUS = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic slot
);

  localparam int W = cnt_width(MODULUS);
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] bitCnt;

  // Reset to the last count so the first enabled edge is already a slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bitCnt <= LAST;
    end else if (enable) begin
      bitCnt <= (bitCnt == LAST) ? '0 : bitCnt + 1'b1;
    end
  end

  assign slot = enable & (bitCnt == LAST);

endmodule

// File: rtl/serializer_word_feeder.sv
// Slices valid/ready frames into LSB-first words for the serializer, one load per word
// period, and fills empty periods with IDLEWORD so the serial stream never stalls.
//
// state | meaning
// IDLE  | no frame in flight; each slot sends IDLEWORD unless a frame is taken
// SEND  | frameReg words being loaded; last slot may chain the next frame
module serializer_word_feeder
  import serializer_feeder_pkg::*;
#(
  parameter int WORDWIDTH = 8,
  parameter int FRAMEWIDTH = 40,
  parameter logic [WORDWIDTH-1:0] IDLEWORD = WORDWIDTH'(DEFAULT_IDLEWORD)
) (
  input  logic                  bitCK,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [FRAMEWIDTH-1:0] frameIn,
  input  logic                  frameValid,
  output logic                  frameReady,
  output logic [WORDWIDTH-1:0]  dout,
  output logic                  load,
  output logic                  idleSent,
  output logic [15:0]           frameCount
);

  localparam int NW = nwords(FRAMEWIDTH, WORDWIDTH);
  localparam int IW = cnt_width(NW);
  localparam logic [IW-1:0] LASTIDX = IW'(NW - 1);

  feeder_state_t         state;
  logic [IW-1:0]         wordIdx;
  logic [IW-1:0]         nextIdx;
  logic [FRAMEWIDTH-1:0] frameReg;
  logic [WORDWIDTH-1:0]  nextWord;
  logic                  slot;
  logic                  transfer;

  slot_counter #(.MODULUS(WORDWIDTH)) u_slot (
    .clk    (bitCK),
    .rstn   (rstn),
    .enable (enable),
    .slot   (slot)
  );

  assign frameReady = slot & ((state == IDLE) | (wordIdx == LASTIDX));
  assign transfer   = frameReady & frameValid;
  assign nextIdx    = wordIdx + 1'b1;

  always_comb begin
    nextWord = frameReg[WORDWIDTH-1:0];
    for (int i = 0; i < NW; i++) begin
      if (nextIdx == IW'(i)) nextWord = frameReg[i*WORDWIDTH +: WORDWIDTH];
    end
  end

  always_ff @(posedge bitCK) begin
    if (!rstn) begin
      state      <= IDLE;
      wordIdx    <= '0;
      load       <= 1'b0;
      idleSent   <= 1'b0;
      dout       <= IDLEWORD;
      frameReg   <= '0;
      frameCount <= '0;
    end else begin
      load     <= 1'b0;
      idleSent <= 1'b0;
      if (transfer) frameCount <= frameCount + 16'd1;
      if (slot) begin
        load <= 1'b1;
        if (transfer) begin
          frameReg <= frameIn;
          dout     <= frameIn[WORDWIDTH-1:0];
          wordIdx  <= '0;
          state    <= SEND;
        end else if ((state == SEND) && (wordIdx != LASTIDX)) begin
          wordIdx <= nextIdx;
          dout    <= nextWord;
        end else begin
          // Covers both an idle slot and a frame ending with nothing queued behind it.
          dout     <= IDLEWORD;
          idleSent <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer_word_feeder.sv
// Bench for serializer_word_feeder: directed scenarios, a randomized run against a
// word-stream reference model, and a 4-bit build checked through a serializer model.
module tb_serializer_word_feeder;
  import serializer_feeder_pkg::*;

  localparam int WW = 8;
  localparam int FW = 40;
  localparam int NW = 5;
  localparam logic [7:0] IDLE8 = 8'h3C;
  localparam logic [3:0] IDLE4 = 4'hA;

  logic bitCK = 1'b0;
  always #5 bitCK = ~bitCK;

  logic          rstn = 1'b0, enable = 1'b0, frameValid = 1'b0;
  logic [FW-1:0] frameIn = '0;
  logic          frameReady, load, idleSent;
  logic [WW-1:0] dout;
  logic [15:0]   frameCount;

  logic          rstn4 = 1'b0, enable4 = 1'b0, fv4 = 1'b0;
  logic [7:0]    fin4 = '0;
  logic          ready4, load4, idle4;
  logic [3:0]    dout4;
  logic [15:0]   count4;

  int errors = 0;
  int checks = 0;

  serializer_word_feeder #(.WORDWIDTH(8), .FRAMEWIDTH(40), .IDLEWORD(IDLE8)) dut (
    .bitCK(bitCK), .rstn(rstn), .enable(enable), .frameIn(frameIn),
    .frameValid(frameValid), .frameReady(frameReady), .dout(dout), .load(load),
    .idleSent(idleSent), .frameCount(frameCount)
  );

  serializer_word_feeder #(.WORDWIDTH(4), .FRAMEWIDTH(8), .IDLEWORD(IDLE4)) dut4 (
    .bitCK(bitCK), .rstn(rstn4), .enable(enable4), .frameIn(fin4),
    .frameValid(fv4), .frameReady(ready4), .dout(dout4), .load(load4),
    .idleSent(idle4), .frameCount(count4)
  );

  // Reference model: a slot every WW enabled edges since reset; a frame is taken only
  // when no words of the previous frame remain to be loaded.
  int          m_en = 0, m_left = 0, m_next = 0;
  logic [FW-1:0] m_frame = '0;
  logic [WW-1:0] m_dout = IDLE8;
  logic        m_load = 1'b0, m_idle = 1'b0;
  logic [15:0] m_count = '0;

  always @(posedge bitCK) begin
    if (!rstn) begin
      m_en = 0; m_left = 0; m_next = 0; m_frame = '0;
      m_dout = IDLE8; m_load = 1'b0; m_idle = 1'b0; m_count = '0;
    end else begin
      m_load = 1'b0; m_idle = 1'b0;
      if (enable) begin
        if (m_en % WW == 0) begin
          m_load = 1'b1;
          if (m_left == 0 && frameValid) begin
            m_frame = frameIn; m_dout = frameIn[WW-1:0];
            m_next = 1; m_left = NW - 1; m_count = m_count + 16'd1;
          end else if (m_left > 0) begin
            m_dout = m_frame[m_next*WW +: WW]; m_next++; m_left--;
          end else begin
            m_dout = IDLE8; m_idle = 1'b1;
          end
        end
        m_en++;
      end
    end
  end

  wire exp_ready = enable && (m_en % WW == 0) && (m_left == 0);

  // LSB-first serializer and receiver on the 4-bit build.
  logic [3:0] sreg4;
  logic       rx_on = 1'b0;
  int         rxpos = 0;
  logic [3:0] rxw;
  logic [3:0] rx[$];

  always @(posedge bitCK) begin
    if (enable4) begin
      if (load4) begin
        sreg4 <= dout4;
        rx_on <= 1'b1;
      end else begin
        sreg4 <= sreg4 >> 1;
      end
    end
  end

  wire sout4 = sreg4[0];

  always @(negedge bitCK) begin
    if (rx_on && enable4) begin
      rxw[rxpos] = sout4;
      rxpos++;
      if (rxpos == 4) begin
        rx.push_back(rxw);
        rxpos = 0;
      end
    end
  end

  function automatic logic [FW-1:0] rand_frame();
    return FW'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; frameValid = 1'b0;
    repeat (2) @(posedge bitCK);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; frameValid = 1'b1; frameIn = rand_frame();
    repeat (2) @(posedge bitCK);
    #1;
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", load); end
    checks++; if (idleSent !== 1'b0) begin errors++; $display("FAIL reset_idleSent got %b want 0", idleSent); end
    checks++; if (dout !== IDLE8) begin errors++; $display("FAIL reset_dout got %h want %h", dout, IDLE8); end
    checks++; if (frameCount !== 16'd0) begin errors++; $display("FAIL reset_frameCount got %0d want 0 (reset beats transfer)", frameCount); end
    frameValid = 1'b0;
  endtask

  task automatic test_idle();
    int nloads = 0;
    do_reset();
    enable = 1'b1; frameValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++;
      if (frameReady !== (c % 8 == 0)) begin
        errors++; $display("FAIL idle_ready cycle %0d got %b want %b", c, frameReady, (c % 8 == 0));
      end
      @(posedge bitCK); #1;
      checks++;
      if (load !== (c % 8 == 0) || idleSent !== (c % 8 == 0) || dout !== IDLE8) begin
        errors++; $display("FAIL idle_word after edge %0d got load=%b idle=%b dout=%h want load=%b idle=%b dout=%h",
                           c, load, idleSent, dout, (c % 8 == 0), (c % 8 == 0), IDLE8);
      end
      if (load) nloads++;
    end
    checks++; if (nloads != 5) begin errors++; $display("FAIL idle_load_count got %0d want 5", nloads); end
  endtask

  task automatic test_single_frame();
    logic [FW-1:0] f = 40'h44_33_22_11_00;
    logic [7:0] w;
    do_reset();
    enable = 1'b1; frameIn = f;
    for (int c = 0; c < 49; c++) begin
      frameValid = (c == 8);
      #1;
      if (c == 8) begin
        checks++; if (frameReady !== 1'b1) begin errors++; $display("FAIL single_ready cycle 8 got %b want 1", frameReady); end
      end
      @(posedge bitCK); #1;
      if (c % 8 == 0) begin
        w = (c == 0 || c == 48) ? IDLE8 : f[(c/8 - 1)*8 +: 8];
        checks++;
        if (load !== 1'b1 || dout !== w || idleSent !== (w == IDLE8)) begin
          errors++; $display("FAIL single_word after edge %0d got load=%b dout=%h idle=%b want load=1 dout=%h idle=%b",
                             c, load, dout, idleSent, w, (w == IDLE8));
        end
      end else begin
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL single_noload after edge %0d got %b want 0", c, load); end
      end
    end
    frameValid = 1'b0;
    checks++; if (frameCount !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", frameCount); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] a, b;
    logic [7:0] w;
    int hs = 0;
    a = rand_frame(); b = rand_frame();
    do_reset();
    enable = 1'b1; frameValid = 1'b1; frameIn = a;
    for (int c = 0; c < 82; c++) begin
      #1;
      if (frameReady && frameValid) hs++;
      @(posedge bitCK); #1;
      if (c == 0) frameIn = b;
      if (c == 40) frameValid = 1'b0;
      if (c % 8 == 0) begin
        w = (c < 40) ? a[(c/8)*8 +: 8] : (c < 80) ? b[(c/8 - 5)*8 +: 8] : IDLE8;
        checks++;
        if (load !== 1'b1 || dout !== w || idleSent !== (c == 80)) begin
          errors++; $display("FAIL b2b_word after edge %0d got load=%b dout=%h idle=%b want load=1 dout=%h idle=%b",
                             c, load, dout, idleSent, w, (c == 80));
        end
      end
    end
    checks++; if (hs != 2) begin errors++; $display("FAIL b2b_handshakes got %0d want 2", hs); end
    checks++; if (frameCount !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", frameCount); end
  endtask

  task automatic test_enable_gap();
    logic [FW-1:0] f;
    logic exp_load;
    logic [7:0] w;
    int ecount = 0;
    f = rand_frame();
    do_reset();
    frameIn = f;
    for (int c = 0; c < 51; c++) begin
      enable = !(c >= 10 && c < 15);
      frameValid = (c == 0);
      #1;
      if (!enable) begin
        checks++; if (frameReady !== 1'b0) begin errors++; $display("FAIL gap_ready cycle %0d got %b want 0", c, frameReady); end
      end
      exp_load = enable && (ecount % 8 == 0);
      w = (ecount / 8 < NW) ? f[(ecount/8)*8 +: 8] : IDLE8;
      @(posedge bitCK); #1;
      checks++;
      if (load !== exp_load || (exp_load && dout !== w) || (!exp_load && idleSent !== 1'b0)) begin
        errors++; $display("FAIL gap_word after edge %0d got load=%b dout=%h idle=%b want load=%b dout=%h",
                           c, load, dout, idleSent, exp_load, w);
      end
      if (enable) ecount++;
    end
    frameValid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [FW-1:0] d, e;
    d = rand_frame(); e = rand_frame();
    do_reset();
    enable = 1'b1; frameValid = 1'b1; frameIn = d;
    for (int c = 0; c < 13; c++) begin
      @(posedge bitCK); #1;
      frameValid = 1'b0;
    end
    // Second reset edge has a ready window and a valid frame; reset must win.
    rstn = 1'b0; frameValid = 1'b1; frameIn = e;
    repeat (2) @(posedge bitCK);
    #1;
    checks++;
    if (load !== 1'b0 || dout !== IDLE8 || frameCount !== 16'd0) begin
      errors++; $display("FAIL midrst_state got load=%b dout=%h count=%0d want load=0 dout=%h count=0",
                         load, dout, frameCount, IDLE8);
    end
    rstn = 1'b1; frameValid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) frameValid = 1'b1;
      #1;
      if (c >= 1) begin
        checks++;
        if (frameReady !== (c == 8)) begin
          errors++; $display("FAIL midrst_ready cycle %0d got %b want %b", c, frameReady, (c == 8));
        end
      end
      @(posedge bitCK); #1;
      if (c == 0) begin
        checks++;
        if (load !== 1'b1 || dout !== IDLE8 || idleSent !== 1'b1) begin
          errors++; $display("FAIL midrst_first got load=%b dout=%h idle=%b want load=1 dout=%h idle=1",
                             load, dout, idleSent, IDLE8);
        end
      end
    end
    frameValid = 1'b0;
    checks++;
    if (load !== 1'b1 || dout !== e[7:0] || frameCount !== 16'd1) begin
      errors++; $display("FAIL midrst_newframe got load=%b dout=%h count=%0d want load=1 dout=%h count=1",
                         load, dout, frameCount, e[7:0]);
    end
  endtask

  task automatic test_random();
    logic accepted;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rstn = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 9) != 0);
      if (!frameValid) begin
        frameValid = ($urandom_range(0, 2) == 0);
        frameIn = rand_frame();
      end
      #1;
      checks++;
      if (frameReady !== exp_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, frameReady, exp_ready);
      end
      accepted = exp_ready && frameValid && rstn;
      @(posedge bitCK); #1;
      checks++;
      if (dout !== m_dout || load !== m_load || idleSent !== m_idle || frameCount !== m_count) begin
        errors++; $display("FAIL rand_outputs after edge %0d got dout=%h load=%b idle=%b count=%0d want dout=%h load=%b idle=%b count=%0d",
                           c, dout, load, idleSent, frameCount, m_dout, m_load, m_idle, m_count);
      end
      if (accepted) frameValid = 1'b0;
    end
    frameValid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] frames [6];
    logic [3:0] expw[$];
    int sent = 0;
    int lastload = -1;
    logic hs;
    for (int i = 0; i < 6; i++) begin
      frames[i] = 8'($urandom());
      expw.push_back(frames[i][3:0]);
      expw.push_back(frames[i][7:4]);
    end
    rstn4 = 1'b0; enable4 = 1'b0; fv4 = 1'b0;
    repeat (2) @(posedge bitCK);
    #1;
    rstn4 = 1'b1; enable4 = 1'b1; fv4 = 1'b1; fin4 = frames[0];
    for (int c = 0; c < 80; c++) begin
      #1;
      hs = ready4 && fv4;
      @(posedge bitCK); #1;
      if (load4) begin
        if (lastload >= 0) begin
          checks++;
          if (c - lastload != 4) begin errors++; $display("FAIL sweep_spacing after edge %0d got %0d want 4", c, c - lastload); end
        end
        lastload = c;
      end
      if (hs) begin
        sent++;
        if (sent < 6) fin4 = frames[sent];
        else fv4 = 1'b0;
      end
    end
    checks++; if (sent != 6) begin errors++; $display("FAIL sweep_sent got %0d want 6", sent); end
    checks++; if (count4 !== 16'd6) begin errors++; $display("FAIL sweep_count got %0d want 6", count4); end
    checks++;
    if (rx.size() < 13) begin
      errors++; $display("FAIL sweep_rx_size got %0d want >=13", rx.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rx[i] !== expw[i]) begin errors++; $display("FAIL sweep_word %0d got %h want %h", i, rx[i], expw[i]); end
      end
      checks++; if (rx[12] !== IDLE4) begin errors++; $display("FAIL sweep_idle got %h want %h", rx[12], IDLE4); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_enable_gap();
    test_reset_midframe();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
